// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code counter family: count directions and
// the legal width range enforced when the counter is elaborated.
package gray_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

endpackage : gray_pkg

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits from the MSB down to that position.
module gray2bin_n
   import gray_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Each bit reduces its own Gray suffix, so there is no ripple through bin.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prefix_xor
      assign bin[gi] = ^gray[WIDTH-1:gi];
   end

endmodule : gray2bin_n

// File: rtl/gray_counter.sv
// Up/down counter holding a binary count with a registered Gray copy, parallel
// load in binary or Gray, and a one-cycle wrap pulse on boundary crossings.
module gray_counter
   import gray_pkg::*;
#(
   parameter int          WIDTH     = 4,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic             load_gray,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_q,
   output logic [WIDTH-1:0] gray_q,
   output logic             wrap
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("gray_counter: WIDTH %0d outside legal range", WIDTH);
   end
   if ((RESET_VAL >> WIDTH) != 0) begin : g_bad_reset
      $error("gray_counter: RESET_VAL %0d does not fit in WIDTH bits", RESET_VAL);
   end

   localparam logic [WIDTH-1:0] RESET_BIN  = RESET_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);
   localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] bin_reg, bin_next;
   logic [WIDTH-1:0] gray_reg, gray_next;
   logic             wrap_reg, wrap_next;
   logic [WIDTH-1:0] load_bin;

   gray2bin_n #(
      .WIDTH (WIDTH)
   ) u_load_conv (
      .gray (load_val),
      .bin  (load_bin)
   );

   always_comb begin
      bin_next  = bin_reg;
      wrap_next = 1'b0;
      if (load) begin
         bin_next = load_gray ? load_bin : load_val;
      end else if (en) begin
         if (up == DIR_UP) begin
            bin_next  = bin_reg + ONE;
            wrap_next = &bin_reg;
         end else begin
            bin_next  = bin_reg - ONE;
            wrap_next = ~|bin_reg;
         end
      end
      // Gray is derived from the next binary value so both registers agree.
      gray_next = bin_next ^ (bin_next >> 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_reg  <= RESET_BIN;
         gray_reg <= RESET_GRAY;
         wrap_reg <= 1'b0;
      end else begin
         bin_reg  <= bin_next;
         gray_reg <= gray_next;
         wrap_reg <= wrap_next;
      end
   end

   assign bin_q  = bin_reg;
   assign gray_q = gray_reg;
   assign wrap   = wrap_reg;

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// Scenario-driven bench for gray_counter (WIDTH 4, RESET_VAL 0): expected
// outputs are queued as stimulus is applied and checked one edge later.
module tb_gray_counter;

   logic       clk = 1'b0;
   logic       rst, en, up, load, load_gray;
   logic [3:0] load_val;
   logic [3:0] bin_q, gray_q;
   logic       wrap;

   typedef struct packed {
      logic [3:0] bin;
      logic [3:0] gray;
      logic       wrap;
   } exp_t;

   typedef struct packed {
      logic       rst;
      logic       en;
      logic       up;
      logic       load;
      logic       lg;
      logic [3:0] lv;
      logic [3:0] ebin;
      logic [3:0] egray;
      logic       ewrap;
   } row_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   gray_counter #(
      .WIDTH     (4),
      .RESET_VAL (0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .up        (up),
      .load      (load),
      .load_gray (load_gray),
      .load_val  (load_val),
      .bin_q     (bin_q),
      .gray_q    (gray_q),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   task automatic apply(input row_t r);
      rst       = r.rst;
      en        = r.en;
      up        = r.up;
      load      = r.load;
      load_gray = r.lg;
      load_val  = r.lv;
      sb.push_back('{bin: r.ebin, gray: r.egray, wrap: r.ewrap});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      row_t r;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         r = '{rst: 1'b1, en: 1'b1, up: 1'b1, load: 1'b0, lg: 1'b0, lv: 4'd5,
               ebin: 4'd0, egray: 4'd0, ewrap: 1'b0};
         apply(r);
         e = sb.pop_front();
         vectors++;
         $display("reset   cyc %0d: bin=%h gray=%b wrap=%b", i, bin_q, gray_q, wrap);
         if ({bin_q, gray_q, wrap} !== e) begin
            miscompares++;
            $display("FAIL reset[%0d]: got bin=%h gray=%b wrap=%b, want bin=%h gray=%b wrap=%b",
                     i, bin_q, gray_q, wrap, e.bin, e.gray, e.wrap);
         end
      end
   endtask

   task automatic test_count_up();
      logic [3:0] gtab [9] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101};
      logic [3:0] prev = 4'b0000;
      row_t r;
      exp_t e;
      for (int i = 0; i < 9; i++) begin
         r = '{rst: 1'b0, en: 1'b1, up: 1'b1, load: 1'b0, lg: 1'b0, lv: 4'd0,
               ebin: 4'(i + 1), egray: gtab[i], ewrap: 1'b0};
         apply(r);
         e = sb.pop_front();
         vectors++;
         $display("count   step %0d: bin=%h gray=%b wrap=%b", i, bin_q, gray_q, wrap);
         if ({bin_q, gray_q, wrap} !== e) begin
            miscompares++;
            $display("FAIL count_up[%0d]: got bin=%h gray=%b wrap=%b, want bin=%h gray=%b wrap=%b",
                     i, bin_q, gray_q, wrap, e.bin, e.gray, e.wrap);
         end
         vectors++;
         if ($countones(gray_q ^ prev) != 1) begin
            miscompares++;
            $display("FAIL one_bit_change[%0d]: got %b -> %b, want exactly one bit flipped",
                     i, prev, gray_q);
         end
         prev = gray_q;
      end
   endtask

   task automatic test_wrap_up();
      row_t r [3] = '{
         '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 4'd15, 4'b1000, 1'b0},
         '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b1},
         '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b0}};
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         apply(r[i]);
         e = sb.pop_front();
         vectors++;
         $display("wrap_up step %0d: bin=%h gray=%b wrap=%b", i, bin_q, gray_q, wrap);
         if ({bin_q, gray_q, wrap} !== e) begin
            miscompares++;
            $display("FAIL wrap_up[%0d]: got bin=%h gray=%b wrap=%b, want bin=%h gray=%b wrap=%b",
                     i, bin_q, gray_q, wrap, e.bin, e.gray, e.wrap);
         end
      end
   endtask

   task automatic test_wrap_down();
      row_t r [2] = '{
         '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 4'b1000, 1'b1},
         '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd14, 4'b1001, 1'b0}};
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         apply(r[i]);
         e = sb.pop_front();
         vectors++;
         $display("wrap_dn step %0d: bin=%h gray=%b wrap=%b", i, bin_q, gray_q, wrap);
         if ({bin_q, gray_q, wrap} !== e) begin
            miscompares++;
            $display("FAIL wrap_down[%0d]: got bin=%h gray=%b wrap=%b, want bin=%h gray=%b wrap=%b",
                     i, bin_q, gray_q, wrap, e.bin, e.gray, e.wrap);
         end
      end
   endtask

   task automatic test_load();
      // Loads of all-ones and zero must not pulse wrap.
      row_t r [4] = '{
         '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010, 4'b1010, 4'b1111, 1'b0},
         '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1101, 4'b1001, 4'b1101, 1'b0},
         '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b1111, 4'b1000, 1'b0},
         '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0}};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         apply(r[i]);
         e = sb.pop_front();
         vectors++;
         $display("load    row %0d: bin=%h gray=%b wrap=%b", i, bin_q, gray_q, wrap);
         if ({bin_q, gray_q, wrap} !== e) begin
            miscompares++;
            $display("FAIL load[%0d]: got bin=%h gray=%b wrap=%b, want bin=%h gray=%b wrap=%b",
                     i, bin_q, gray_q, wrap, e.bin, e.gray, e.wrap);
         end
      end
   endtask

   task automatic test_back_to_back();
      row_t r [4] = '{
         '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd9,  4'b1101, 1'b0},
         '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd10, 4'b1111, 1'b0},
         '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9,  4'b1101, 1'b0},
         '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd8,  4'b1100, 1'b0}};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         apply(r[i]);
         e = sb.pop_front();
         vectors++;
         $display("dirflip step %0d: bin=%h gray=%b wrap=%b", i, bin_q, gray_q, wrap);
         if ({bin_q, gray_q, wrap} !== e) begin
            miscompares++;
            $display("FAIL back_to_back[%0d]: got bin=%h gray=%b wrap=%b, want bin=%h gray=%b wrap=%b",
                     i, bin_q, gray_q, wrap, e.bin, e.gray, e.wrap);
         end
      end
   endtask

   task automatic test_rst_priority();
      row_t r [4] = '{
         '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd7, 4'b0100, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd0, 4'b0000, 1'b0},
         '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd1, 4'b0001, 1'b0},
         '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd2, 4'b0011, 1'b0}};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         apply(r[i]);
         e = sb.pop_front();
         vectors++;
         $display("rst_pri step %0d: bin=%h gray=%b wrap=%b", i, bin_q, gray_q, wrap);
         if ({bin_q, gray_q, wrap} !== e) begin
            miscompares++;
            $display("FAIL rst_priority[%0d]: got bin=%h gray=%b wrap=%b, want bin=%h gray=%b wrap=%b",
                     i, bin_q, gray_q, wrap, e.bin, e.gray, e.wrap);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      up        = 1'b1;
      load      = 1'b0;
      load_gray = 1'b0;
      load_val  = 4'd0;
      @(posedge clk);
      #1;
      test_reset();
      test_count_up();
      test_wrap_up();
      test_wrap_down();
      test_load();
      test_back_to_back();
      test_rst_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_gray_counter

// File: doc/gray_counter.md
# gray_counter

Parametrised up/down Gray-code counter with registered binary and Gray outputs, parallel load in either code, and a wrap indication. It generalises the team's 4-bit combinational binary-to-Gray converter into a clocked, width-configurable block. It is intended as the pointer/sequence generator for single-bit-change status buses and for later clock-domain-crossing FIFO work.

## Interface
Parameters:
- `WIDTH`, default 4, counter width in bits; legal range 2..32.
- `RESET_VAL`, default 0, binary value loaded into the counter on reset; must be less than 2^WIDTH.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  count enable; one step per cycle while high.
- `up`  in  1  direction; 1 = increment, 0 = decrement.
- `load`  in  1  parallel load strobe.
- `load_gray`  in  1  load code select; 1 = `load_val` is Gray, 0 = binary.
- `load_val`  in  WIDTH  load value.
- `bin_q`  out  WIDTH  registered binary count.
- `gray_q`  out  WIDTH  registered Gray code of `bin_q`.
- `wrap`  out  1  registered one-cycle pulse on a count wrap-around.

## Operation
- State is a WIDTH-bit binary register. `gray_q` is also registered and is always equal to `bin_q ^ (bin_q >> 1)`. It is computed from the next binary value, so both outputs update on the same edge and never disagree.
- Priority per edge: `rst` > `load` > `en` > hold.
- `rst`: `bin_q` = RESET_VAL, `gray_q` = Gray(RESET_VAL), `wrap` = 0. With defaults, all outputs are 0.
- `load`: `bin_q` = `load_val` when `load_gray` = 0. When `load_gray` = 1, `bin_q` = Gray-to-binary(`load_val`), where b[W-1] = g[W-1] and b[i] = b[i+1] ^ g[i]. `en` and `up` are ignored that cycle, and `wrap` = 0.
- `en` without `load`:
  - `up` = 1: `bin_q` = `bin_q` + 1, modulo 2^WIDTH.
  - `up` = 0: `bin_q` = `bin_q` − 1, modulo 2^WIDTH.
- `wrap` = 1 for exactly the cycle after a counting step that crosses the boundary:
  - up from all-ones to 0;
  - down from 0 to all-ones.
- `wrap` = 0 in every other case, including a load of 0 or all-ones.
- Hold (no `rst`, `load` or `en`): all registers keep their value and `wrap` = 0.
- Direction may change on any cycle. The step taken uses the `up` value sampled on that edge.
- Invariant: consecutive `gray_q` values produced by counting steps differ in exactly one bit, and this holds across the wrap boundary. Loads are exempt.
- All arithmetic is unsigned WIDTH-bit; carries and borrows out of the MSB are discarded.

## Timing
- Latency of 1 cycle for every input to every output. Inputs are sampled on rising edge N, and outputs show the result after edge N.
- There is no combinational path from any input to any output.
- Reset takes effect on the first rising edge with `rst` high. A reset asserted mid-count or coincident with `load` or `en` overrides them on that edge. Counting resumes from RESET_VAL on the first edge with `rst` low and `en` high.
- Maximum count rate is one step per cycle; there is no handshake and no backpressure.

## Structure
- Shared package `gray_pkg` holds:
  - direction constants `DIR_UP` = 1'b1 and `DIR_DOWN` = 1'b0;
  - the legal WIDTH bounds, as constants checked by an elaboration-time assertion.
- One sub-module, `gray2bin_n`: parametrised WIDTH, purely combinational prefix-XOR, used on the load path.
- The binary-to-Gray step is a single XOR expression in the top level and does not need its own module.

## Test plan
All scenarios use WIDTH = 4 and RESET_VAL = 0.
- Reset, then hold `rst` for 2 cycles -> `bin_q` = 0, `gray_q` = 0, `wrap` = 0 on every cycle.
- `en` = 1, `up` = 1 for 9 cycles from 0 -> `bin_q` steps 1..9. `gray_q` steps 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101. Each step changes exactly one Gray bit.
- Load binary 15, then one up step -> `bin_q` = 0, `gray_q` goes 1000 -> 0000, `wrap` = 1 for one cycle.
- From 0, one down step -> `bin_q` = 15, `gray_q` = 1000, `wrap` = 1 for one cycle. A further down step gives `bin_q` = 14, `gray_q` = 1001, `wrap` = 0.
- Loads, each with `en` = 1 in the same cycle:
  - `load_gray` = 0, `load_val` = 1010 -> `bin_q` = 1010, `gray_q` = 1111.
  - `load_gray` = 1, `load_val` = 1101 -> `bin_q` = 1001, `gray_q` = 1101.
- `rst`, `load` and `en` all high together, with `bin_q` = 7 -> next `bin_q` = 0, `gray_q` = 0, `wrap` = 0. Counting resumes from 0 after `rst` drops.
